// File: rtl/uart_tx_frame_cfg.sv
// rtl/uart_tx_frame_cfg.sv - configurable UART transmitter with one-entry holding register
// Optional parity state and generator: define UART_TX_PARITY_EN.
module uart_tx_frame_cfg #(
    parameter int MaxDataBits = 9
) (
    input  logic                   clk,
    input  logic                   syncReset,
    input  logic                   en,
    input  logic [MaxDataBits-1:0] data,
    input  logic                   valid,
    output logic                   ready,
    input  logic [3:0]             dataBits,
    input  logic [1:0]             parityMode,
    input  logic                   stopBits,
    output logic                   out,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_e;

    localparam logic [3:0] MaxBits = 4'(MaxDataBits);

    state_e                 state_q, state_d;
    logic                   hold_full_q, hold_full_d;
    logic [MaxDataBits-1:0] hold_data_q, hold_data_d;
    logic [3:0]             hold_bits_q, hold_bits_d;
    logic                   hold_stop2_q, hold_stop2_d;
    logic [MaxDataBits-1:0] shift_q, shift_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [3:0]             cur_bits_q, cur_bits_d;
    logic                   cur_stop2_q, cur_stop2_d;
    logic                   out_q, out_d;
    logic                   load, frame_end, accept;
    logic [3:0]             bits_clamped;
    logic [MaxDataBits-1:0] bits_mask;
`ifdef UART_TX_PARITY_EN
    logic hold_par_en_q, hold_par_en_d, hold_par_odd_q, hold_par_odd_d;
    logic cur_par_en_q, cur_par_en_d, par_bit_q, par_bit_d;
`else
    logic unused_parity;
    assign unused_parity = ^parityMode;
`endif

    assign accept = valid && !hold_full_q;

    // Payload bits beyond the clamped width are zeroed so parity can use a plain reduction.
    always_comb begin
        if (dataBits < 4'd5)
            bits_clamped = 4'd5;
        else if (dataBits > MaxBits)
            bits_clamped = MaxBits;
        else
            bits_clamped = dataBits;
        for (int i = 0; i < MaxDataBits; i++)
            bits_mask[i] = (4'(i) < bits_clamped);
    end

    always_ff @(posedge clk) begin
        if (syncReset) begin
            state_q      <= S_IDLE;
            hold_full_q  <= 1'b0;
            hold_data_q  <= '0;
            hold_bits_q  <= 4'd5;
            hold_stop2_q <= 1'b0;
            shift_q      <= '0;
            cnt_q        <= 4'd0;
            cur_bits_q   <= 4'd5;
            cur_stop2_q  <= 1'b0;
            out_q        <= 1'b1;
`ifdef UART_TX_PARITY_EN
            hold_par_en_q  <= 1'b0;
            hold_par_odd_q <= 1'b0;
            cur_par_en_q   <= 1'b0;
            par_bit_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            hold_full_q  <= hold_full_d;
            hold_data_q  <= hold_data_d;
            hold_bits_q  <= hold_bits_d;
            hold_stop2_q <= hold_stop2_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            cur_bits_q   <= cur_bits_d;
            cur_stop2_q  <= cur_stop2_d;
            out_q        <= out_d;
`ifdef UART_TX_PARITY_EN
            hold_par_en_q  <= hold_par_en_d;
            hold_par_odd_q <= hold_par_odd_d;
            cur_par_en_q   <= cur_par_en_d;
            par_bit_q      <= par_bit_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        frame_end = 1'b0;
        if (en) begin
            case (state_q)
                S_IDLE:  state_d = S_IDLE;
                S_START: state_d = S_DATA;
                S_DATA: begin
                    if (cnt_q == 4'd0) begin
`ifdef UART_TX_PARITY_EN
                        state_d = cur_par_en_q ? S_PARITY : S_STOP1;
`else
                        state_d = S_STOP1;
`endif
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: state_d = S_STOP1;
`endif
                S_STOP1: begin
                    if (cur_stop2_q)
                        state_d = S_STOP2;
                    else
                        frame_end = 1'b1;
                end
                S_STOP2: frame_end = 1'b1;
                default: state_d = S_IDLE;
            endcase
            // A waiting payload starts its START bit on the very tick that ends the previous frame.
            if ((state_q == S_IDLE) || frame_end) begin
                if (hold_full_q) begin
                    state_d = S_START;
                    load    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
        end
    end

    always_comb begin
        hold_full_d  = hold_full_q;
        hold_data_d  = hold_data_q;
        hold_bits_d  = hold_bits_q;
        hold_stop2_d = hold_stop2_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        cur_bits_d   = cur_bits_q;
        cur_stop2_d  = cur_stop2_q;
`ifdef UART_TX_PARITY_EN
        hold_par_en_d  = hold_par_en_q;
        hold_par_odd_d = hold_par_odd_q;
        cur_par_en_d   = cur_par_en_q;
        par_bit_d      = par_bit_q;
`endif
        if (accept) begin
            hold_full_d  = 1'b1;
            hold_data_d  = data & bits_mask;
            hold_bits_d  = bits_clamped;
            hold_stop2_d = stopBits;
`ifdef UART_TX_PARITY_EN
            hold_par_en_d  = (parityMode == 2'b01) || (parityMode == 2'b10);
            hold_par_odd_d = (parityMode == 2'b10);
`endif
        end
        if (load) begin
            hold_full_d = 1'b0;
            shift_d     = hold_data_q;
            cur_bits_d  = hold_bits_q;
            cur_stop2_d = hold_stop2_q;
`ifdef UART_TX_PARITY_EN
            cur_par_en_d = hold_par_en_q;
            par_bit_d    = (^hold_data_q) ^ hold_par_odd_q;
`endif
        end else if (en && (state_q == S_START)) begin
            cnt_d = cur_bits_q - 4'd1;
        end else if (en && (state_q == S_DATA)) begin
            shift_d = shift_q >> 1;
            if (cnt_q != 4'd0)
                cnt_d = cnt_q - 4'd1;
        end
    end

    always_comb begin
        out_d = 1'b1;
        case (state_d)
            S_START:  out_d = 1'b0;
            S_DATA:   out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: out_d = par_bit_d;
`endif
            default:  out_d = 1'b1;
        endcase
    end

    assign out   = out_q;
    assign ready = !hold_full_q;
    assign busy  = (state_q != S_IDLE) || hold_full_q;
    assign done  = frame_end;
endmodule
